// File: rtl/tick_sched_if.sv
// Configuration port of the tick scheduler: one valid/ready request
// carrying a target channel, a divide value and an enable state.
interface tick_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 16
);
  localparam int CW = $clog2(NCH);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [DW-1:0] cfg_div;
  logic          cfg_en;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/tick_sched.sv
// Multi-channel clock-enable scheduler. Each channel runs a programmable
// divider producing a one-cycle tick at terminal count and a square-wave
// toggle. Rate/enable updates go through a single-entry pending buffer and
// land on a running channel only at its terminal count, so a period is
// never cut short.
module tick_sched #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int RST_DIV = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  tick_sched_if.slave    cfg,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_tgl,
  output logic [NCH-1:0] ch_en
);

  localparam int CW = $clog2(NCH);

  logic [DW-1:0]  div_q [NCH];
  logic [DW-1:0]  cnt_q [NCH];
  logic [NCH-1:0] en_q;
  logic [NCH-1:0] tgl_q;
  logic [NCH-1:0] tick_q;

  logic           pend_q;
  logic [CW-1:0]  pend_ch_q;
  logic [DW-1:0]  pend_div_q;
  logic           pend_en_q;

  logic [NCH-1:0] hit;
  logic [NCH-1:0] apply;
  logic           drop;
  logic           accept;

  assign accept = cfg.cfg_valid && !pend_q;

  // Terminal-count detect and pending-update steering per channel.
  // A disabled target takes the update at once; an enabled one waits for
  // its terminal count. Out-of-range channel selects are simply dropped.
  always_comb begin
    hit   = '0;
    apply = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i]   = en_q[i] && (cnt_q[i] == div_q[i]);
      apply[i] = pend_q && (pend_ch_q == CW'(i)) && (!en_q[i] || hit[i]);
    end
    drop = pend_q && (int'(pend_ch_q) >= NCH);
  end

  // Per-channel divider state: counter, divide value, enable, tick, toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= (i == 0) ? DW'(RST_DIV) : '0;
      end
      en_q   <= NCH'(1);
      tgl_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        tick_q[i] <= hit[i];
        tgl_q[i]  <= tgl_q[i] ^ hit[i];
        if (apply[i]) begin
          div_q[i] <= pend_div_q;
          en_q[i]  <= pend_en_q;
          cnt_q[i] <= '0;
        end else if (hit[i] || !en_q[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Pending-buffer occupancy; it also drives the ready handshake, so a
  // request can never be accepted on the same edge one is retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (accept) begin
      pend_q <= 1'b1;
    end else if ((|apply) || drop) begin
      pend_q <= 1'b0;
    end
  end

  // Pending payload; only meaningful while the buffer is occupied.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_ch_q  <= cfg.cfg_ch;
      pend_div_q <= cfg.cfg_div;
      pend_en_q  <= cfg.cfg_en;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign tick          = tick_q;
  assign clk_tgl       = tgl_q;
  assign ch_en         = en_q;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: a timeline model predicts every cycle's outputs
// into a queue; a monitor pops and compares on each falling clock edge.
module tb_tick_sched;
  localparam int NCH     = 4;
  localparam int DW      = 16;
  localparam int RST_DIV = 8;
  localparam int CW      = $clog2(NCH);

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_tgl;
  logic [NCH-1:0] ch_en;

  tick_sched_if #(.NCH(NCH), .DW(DW)) cfg_if ();

  tick_sched #(.NCH(NCH), .DW(DW), .RST_DIV(RST_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg     (cfg_if),
    .tick    (tick),
    .clk_tgl (clk_tgl),
    .ch_en   (ch_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] tgl;
    logic [NCH-1:0] en;
    logic           rdy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: absolute edge number of each channel's next tick.
  int div_m [NCH];
  int nt_m  [NCH];
  bit en_m  [NCH];
  bit tgl_m [NCH];
  bit pend_m;
  int pch_m;
  int pdiv_m;
  bit pen_m;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      div_m[i] = (i == 0) ? RST_DIV : 0;
      en_m[i]  = (i == 0);
      tgl_m[i] = 1'b0;
      nt_m[i]  = (i == 0) ? RST_DIV + 1 : 0;
    end
    pend_m = 1'b0;
  endtask

  // Model: predicts outputs after every rising edge out of reset.
  initial begin : model
    int   e;
    bit   acc;
    bit   hit [NCH];
    exp_t x;
    e = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        q.delete();
        e = 0;
      end else begin
        e++;
        acc = cfg_if.cfg_valid && !pend_m;
        for (int i = 0; i < NCH; i++) begin
          hit[i] = en_m[i] && (e == nt_m[i]);
          if (hit[i]) begin
            tgl_m[i] = !tgl_m[i];
            nt_m[i]  = e + div_m[i] + 1;
          end
        end
        if (pend_m) begin
          if (pch_m >= NCH) begin
            pend_m = 1'b0;
          end else if (!en_m[pch_m] || hit[pch_m]) begin
            en_m[pch_m]  = pen_m;
            div_m[pch_m] = pdiv_m;
            nt_m[pch_m]  = e + pdiv_m + 1;
            pend_m       = 1'b0;
          end
        end
        if (acc) begin
          pch_m  = int'(cfg_if.cfg_ch);
          pdiv_m = int'(cfg_if.cfg_div);
          pen_m  = cfg_if.cfg_en;
          pend_m = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
          x.tick[i] = hit[i];
          x.tgl[i]  = tgl_m[i];
          x.en[i]   = en_m[i];
        end
        x.rdy = !pend_m;
        q.push_back(x);
      end
    end
  end

  // Monitor: reset values while in reset, model predictions otherwise.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        total++;
        if (tick !== '0 || clk_tgl !== '0 || ch_en !== NCH'(1) || cfg_if.cfg_ready !== 1'b1) begin
          bad++;
          $display("FAIL reset_state t=%0t got tick=%b tgl=%b en=%b rdy=%b want tick=0 tgl=0 en=%b rdy=1",
                   $time, tick, clk_tgl, ch_en, cfg_if.cfg_ready, NCH'(1));
        end
      end else if (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if (tick !== x.tick || clk_tgl !== x.tgl || ch_en !== x.en || cfg_if.cfg_ready !== x.rdy) begin
          bad++;
          $display("FAIL cycle_outputs t=%0t got tick=%b tgl=%b en=%b rdy=%b want tick=%b tgl=%b en=%b rdy=%b",
                   $time, tick, clk_tgl, ch_en, cfg_if.cfg_ready, x.tick, x.tgl, x.en, x.rdy);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cfg_if.cfg_ready) begin
      n++;
      if (n > 200) begin
        $display("FAIL cfg_ready_timeout t=%0t got rdy=0 want rdy=1 within 200 cycles", $time);
        $fatal(1, "cfg_ready never rose");
      end
      @(negedge clk);
    end
  endtask

  task automatic cfg_write(input int ch, input int d, input bit en);
    @(negedge clk);
    wait_ready();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CW'(ch);
    cfg_if.cfg_div   = DW'(d);
    cfg_if.cfg_en    = en;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch);
    int n = 0;
    @(negedge clk);
    while (!tick[ch]) begin
      n++;
      if (n > 200) begin
        $display("FAIL tick_timeout ch=%0d t=%0t got no tick want tick within 200 cycles", ch, $time);
        $fatal(1, "tick never seen");
      end
      @(negedge clk);
    end
  endtask

  // Stimulus: directed scenarios followed by randomized writes.
  initial begin : stim
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_en    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    cfg_write(1, 3, 1'b1);
    repeat (20) @(negedge clk);

    wait_tick(0);
    repeat (2) @(negedge clk);
    cfg_write(0, 2, 1'b1);
    repeat (20) @(negedge clk);

    cfg_write(1, 3, 1'b0);
    repeat (15) @(negedge clk);

    cfg_write(2, 0, 1'b1);
    repeat (10) @(negedge clk);

    // Async reset while a write to channel 0 is still pending.
    @(negedge clk);
    wait_ready();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CW'(0);
    cfg_if.cfg_div   = DW'(5);
    cfg_if.cfg_en    = 1'b1;
    @(posedge clk);
    #2;
    rst_n            = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);

    for (int k = 0; k < 150; k++) begin
      cfg_write($urandom_range(0, NCH - 1), $urandom_range(0, 6), ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
# tick_sched

Multi-channel clock-enable scheduler for the 2048 display/game logic. It generates NCH independent one-cycle tick pulses and divided square-wave toggles from the single system clock. Each channel runs its own programmable divider and replaces free-running per-module dividers. A valid/ready configuration port sequences rate changes and enables, with updates applied only at a channel's terminal count so no tick is ever truncated. At reset, channel 0 comes up enabled at the legacy slow-clock rate (divide value 8, i.e. one toggle every 9 clocks).

## Interface
- NCH, 4: number of channels (≥2).
- DW, 16: divide-value width.
- RST_DIV, 8: channel 0 divide value at reset.
- CW, $clog2(NCH): channel-select width (derived).
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config port can accept a request (no update pending).
- cfg_ch  in  CW  target channel.
- cfg_div  in  DW  new divide value D (period D+1 clocks).
- cfg_en  in  1  new enable state.
- tick  out  NCH  per-channel one-cycle pulse at each terminal count.
- clk_tgl  out  NCH  per-channel toggle; half-period is D+1 clocks.
- ch_en  out  NCH  current enable state per channel.

## Operation
- Per-channel state: div[DW], cnt[DW], en, tgl.
- Enabled channel, at each edge:
  - If cnt==div: cnt←0, tick←1, tgl←~tgl.
  - Otherwise: cnt←cnt+1, tick←0.
- Disabled channel: cnt holds 0, tick is 0, tgl holds its last value.
- D=0 gives a tick every cycle and a toggle every cycle.
- Config port has a single-entry pending buffer:
  - A request is accepted at the edge where cfg_valid && cfg_ready.
  - On accept, {ch, div, en} are latched and cfg_ready drops.
- Applying the pending update:
  - Target disabled: apply at the next edge.
  - Target enabled: apply at the first edge where that channel's cnt==div. That edge's tick and toggle still occur.
  - Apply action: div←new, en←new, cnt←0. cfg_ready rises after the apply edge.
- A write that disables a running channel lets its current period complete, then the channel stops.
- A rewrite of identical values to a running channel still waits for the terminal count and restarts cnt at 0 (no phase change, since cnt is already 0).
- cfg_ch ≥ NCH (non-power-of-2 NCH): accepted, then discarded at the next edge; cfg_ready rises after that edge.
- cnt is never greater than div, because div changes only at cnt==0. The comparison is plain equality on DW bits; cnt never wraps.
- Other channels are unaffected by any config activity.

## Timing
- Reset (async assert):
  - All cnt=0, tick=0, clk_tgl=0, pending cleared, cfg_ready=1.
  - ch_en=1 for channel 0 with div=RST_DIV; ch_en=0 for all others with div=0.
- Release: channel 0 counts from the first edge after rst_n rises. First tick is high in the cycle after edge RST_DIV+1.
- Accept edge E0, disabled target, new D:
  - Applied at E1; cfg_ready=1 after E1.
  - First tick is high in the cycle after edge E1+D+1. Ticks then repeat every D+1 cycles.
- Accept to running target: apply latency ≤ old D+1 edges after E0. The new period starts immediately after the apply edge.
- cfg_ready is low for at least one cycle after every accept. Back-to-back accepts are impossible.
- ch_en updates at the apply edge.
- Reset mid-operation: the pending request is dropped and all outputs return to reset values immediately.

## Test plan
- Reset, then run 40 clocks:
  - tick[0] pulses every 9 cycles (first after edge 9).
  - clk_tgl[0] toggles on the same edges.
  - tick[3:1]=0 and ch_en=4'b0001.
- While channel 1 is disabled, write ch1 D=3 en=1:
  - cfg_ready is low for exactly 1 cycle.
  - tick[1] first high after edge E1+4, then every 4 cycles.
- While channel 0 runs at D=8, write ch0 D=2 mid-period (cnt=3):
  - Apply happens at the next cnt==8 edge, with that tick still emitted.
  - Subsequent ticks come every 3 cycles; cfg_ready stays low until apply.
- Write ch1 en=0 while running at D=3:
  - The current period completes with a final tick.
  - ch_en[1] falls at the apply edge; clk_tgl[1] then holds its value.
- Write ch2 D=0 en=1:
  - tick[2] is constantly 1 from the cycle after edge E1+1.
  - clk_tgl[2] toggles every cycle.
- Assert rst_n=0 asynchronously while a write to ch0 is pending:
  - Outputs reset with no clock edge required.
  - The pending update is lost; after release, channel 0 runs at D=8 again.
